fir_coef_loader: RTL and testbench
==================================

// Module: fir_coef_loader
// PURPOSE
//  Drives the coefficient shift chain of the adjustable-tap generic FIR.
//  Collects NTAPS coefficients from an upstream valid/ready stream into a
//  local buffer without disturbing the running filter. Once a complete,
//  correctly framed set has arrived, it shifts the set into the tap chain,
//  one o_tap_wr pulse per cycle. After NTAPS pulses, received coef k sits
//  at chain position k, where position 0 is the tap nearest the loader.
// PARAMETERS
//  NTAPS  128  number of taps in the chain; must be >= 2
//  TW     16   coefficient width in bits; equals the tap width of the chain
//  LGN    $clog2(NTAPS+1)  counter width (derived; not overridden)
// PORTS
//  i_clk        in   1   system clock; all logic is on its rising edge
//  i_reset_n    in   1   asynchronous reset, active low
//  i_coef_valid in   1   upstream coefficient beat valid
//  o_coef_ready out  1   loader can accept a beat
//  i_coef       in   TW  coefficient value
//  i_coef_last  in   1   marks the final beat of a set
//  o_tap_wr     out  1   shift strobe to the chain (the chain's i_tap_wr)
//  o_tap        out  TW  coefficient presented to chain position 0
//  o_busy       out  1   loader is shifting; chain taps are in flux
//  o_done       out  1   one-cycle pulse: new set fully loaded
//  o_err        out  1   one-cycle pulse: framing error, set discarded
// BEHAVIOUR
//  Reset values (async, on i_reset_n low):
//   - o_tap_wr=0, o_tap=0, o_busy=0, o_done=0, o_err=0.
//   - State=COLLECT, count=0, o_coef_ready=1.
//   - Buffer contents are don't-care.
//  States: COLLECT, SHIFT.
//   - o_coef_ready = (state==COLLECT).
//   - o_busy = (state==SHIFT).
//  COLLECT, on accept (valid & ready):
//   - buf[count] <= i_coef.
//   - If i_coef_last and count==NTAPS-1: count<=0, go to SHIFT.
//   - Else if i_coef_last, or count==NTAPS-1 with last low: framing error.
//     o_err=1 next cycle, count<=0, beat dropped, stay in COLLECT.
//   - Otherwise: count<=count+1.
//   - A framing error never touches the chain. No o_tap_wr is issued.
//  SHIFT: let cycle t be the cycle that accepted the last beat.
//   - Cycles t+1..t+NTAPS: o_tap_wr=1, o_tap=buf[NTAPS-1-j] on pulse j.
//     So the first pulse carries the last-received coefficient.
//   - o_tap_wr is strictly contiguous; exactly NTAPS pulses per set.
//   - Cycle t+NTAPS+1: o_tap_wr=0, o_done=1, state=COLLECT, ready=1.
//   - A beat may be accepted in the same cycle as o_done.
//  Registered outputs:
//   - o_tap_wr, o_tap, o_done and o_err are registered.
//   - o_tap holds its last value while o_tap_wr=0.
//  Back-pressure:
//   - valid may be held while ready=0; no beat is lost or duplicated.
//   - Data is sampled only on valid & ready.
//  Reset mid-SHIFT:
//   - o_tap_wr drops asynchronously.
//   - The chain keeps a partial mix of old and new taps.
//   - Upstream must resend the full set; no o_done is issued.
//  Width: coefficients are passed bit-exact; no sign change, no rounding.
// TESTING  (NTAPS=4, TW=16)
//  1. Send 1,2,3,4 with last on 4 -> 4 pulses carrying 4,3,2,1.
//     o_done on the 5th cycle after the last beat; chain = {1,2,3,4}.
//  2. Send 1,2 with last on 2 -> o_err pulse, no o_tap_wr.
//     Then send 5,6,7,8 -> pulses 8,7,6,5.
//  3. Send 4 beats with last low -> o_err after the 4th beat, count=0.
//     Next valid set loads normally.
//  4. Hold valid high with a second set during SHIFT -> ready=0 for 4 cycles.
//     Second set accepted from the o_done cycle; its pulses follow correctly.
//  5. Assert i_reset_n low after the 2nd pulse -> o_tap_wr=0 immediately.
//     After reset release: ready=1, no o_done.
//  6. Random valid gaps plus 0x8000/0x7FFF values -> pulse values bit-exact.
//     Pulse count is always 4 per set.

Source files
------------

// File: rtl/fir_coef_loader_if.sv
// Upstream coefficient stream (valid/ready) feeding the FIR coefficient loader.
// The master is the coefficient source and the slave is the loader.
interface fir_coef_loader_if #(
    parameter int TW = 16
) ();
    logic          i_coef_valid;
    logic          o_coef_ready;
    logic [TW-1:0] i_coef;
    logic          i_coef_last;

    modport master (
        output i_coef_valid,
        output i_coef,
        output i_coef_last,
        input  o_coef_ready
    );

    modport slave (
        input  i_coef_valid,
        input  i_coef,
        input  i_coef_last,
        output o_coef_ready
    );
endinterface

// File: rtl/fir_coef_loader.sv
// Buffers a framed set of NTAPS coefficients, then shifts it into the FIR tap
// chain last-received-first, so coefficient k ends up at chain position k.
module fir_coef_loader #(
    parameter  int NTAPS = 128,
    parameter  int TW    = 16,
    localparam int LGN   = $clog2(NTAPS + 1)
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    fir_coef_loader_if.slave coef,
    output logic            o_tap_wr,
    output logic [TW-1:0]   o_tap,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_err
);

    localparam int AW = (NTAPS > 1) ? $clog2(NTAPS) : 1;

    typedef enum logic {
        COLLECT = 1'b0,
        SHIFT   = 1'b1
    } state_t;

    state_t          state;
    state_t          state_d;
    logic [LGN-1:0]  count;
    logic [LGN-1:0]  count_d;
    logic            tap_wr_d;
    logic [TW-1:0]   tap_d;
    logic            done_d;
    logic            err_d;

    logic [TW-1:0]   coef_buf [NTAPS];
    logic            accept;
    logic            at_end;
    logic [AW-1:0]   wr_idx;
    logic [AW-1:0]   rd_idx;

    assign accept = coef.i_coef_valid && coef.o_coef_ready;
    assign at_end = (count == LGN'(NTAPS - 1));
    assign wr_idx = count[AW-1:0];
    // Pulse 0 comes straight from the final beat, so SHIFT starts reading at NTAPS-2.
    assign rd_idx = AW'(NTAPS - 2) - count[AW-1:0];

    // NOTE: the coefficient buffer is deliberately not reset; every entry is
    // written before it is read, and a reset-free array maps onto plain RAM.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            coef_buf[wr_idx] <= coef.i_coef;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state    <= COLLECT;
            count    <= '0;
            o_tap_wr <= 1'b0;
            o_tap    <= '0;
            o_done   <= 1'b0;
            o_err    <= 1'b0;
        end else begin
            state    <= state_d;
            count    <= count_d;
            o_tap_wr <= tap_wr_d;
            o_tap    <= tap_d;
            o_done   <= done_d;
            o_err    <= err_d;
        end
    end

    // NOTE: every signal written in a combinational block gets a default first,
    // otherwise a missed branch would infer a latch.
    always_comb begin
        state_d = state;
        count_d = count;
        unique case (state)
            COLLECT: begin
                if (accept) begin
                    if (coef.i_coef_last && at_end) begin
                        state_d = SHIFT;
                        count_d = '0;
                    end else if (coef.i_coef_last || at_end) begin
                        count_d = '0;
                    end else begin
                        count_d = count + LGN'(1);
                    end
                end
            end
            SHIFT: begin
                if (at_end) begin
                    state_d = COLLECT;
                    count_d = '0;
                end else begin
                    count_d = count + LGN'(1);
                end
            end
            default: begin
                state_d = COLLECT;
                count_d = '0;
            end
        endcase
    end

    // Next values of the registered outputs, plus the state-decoded handshake flags.
    always_comb begin
        tap_wr_d          = 1'b0;
        tap_d             = o_tap;
        done_d            = 1'b0;
        err_d             = 1'b0;
        coef.o_coef_ready = (state == COLLECT);
        o_busy            = (state == SHIFT);
        unique case (state)
            COLLECT: begin
                if (accept) begin
                    if (coef.i_coef_last && at_end) begin
                        tap_wr_d = 1'b1;
                        tap_d    = coef.i_coef;
                    end else if (coef.i_coef_last || at_end) begin
                        err_d = 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (at_end) begin
                    done_d = 1'b1;
                end else begin
                    tap_wr_d = 1'b1;
                    tap_d    = coef_buf[rd_idx];
                end
            end
            default: begin
                tap_wr_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_fir_coef_loader.sv
// Scoreboard bench for fir_coef_loader with NTAPS=4: expected pulse values are
// queued when a set's last beat is driven and popped on every o_tap_wr.
module tb_fir_coef_loader;

    localparam int NT = 4;
    localparam int TW = 16;

    typedef logic [TW-1:0] word_t;
    typedef word_t set_t [NT];

    logic  clk   = 1'b0;
    logic  rst_n = 1'b0;
    logic  tap_wr;
    word_t tap;
    logic  busy;
    logic  done;
    logic  err;

    always #5 clk = ~clk;

    fir_coef_loader_if #(.TW(TW)) coef_bus ();

    fir_coef_loader #(
        .NTAPS(NT),
        .TW   (TW)
    ) dut (
        .i_clk    (clk),
        .i_reset_n(rst_n),
        .coef     (coef_bus),
        .o_tap_wr (tap_wr),
        .o_tap    (tap),
        .o_busy   (busy),
        .o_done   (done),
        .o_err    (err)
    );

    int    vectors     = 0;
    int    miscompares = 0;
    word_t exp_q [$];
    word_t exp_v;
    word_t chain [NT];
    int    run    = 0;
    int    pulses = 0;
    int    dones  = 0;
    int    errs   = 0;

    // Downstream tap chain: position 0 takes o_tap, the rest shift outward.
    always @(posedge clk) begin
        if (tap_wr) begin
            chain[0] <= tap;
            for (int k = 1; k < NT; k++) chain[k] <= chain[k-1];
        end
    end

    // Scoreboard and pulse-run monitor.
    always @(negedge clk) begin
        if (done) dones++;
        if (err) errs++;
        if (tap_wr) begin
            pulses++;
            run++;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL tap_unexpected: pulse carrying %h, required no pulse", tap);
            end else begin
                exp_v = exp_q.pop_front();
                if (tap !== exp_v) begin
                    miscompares++;
                    $display("FAIL tap_value: got %h, required %h", tap, exp_v);
                end
            end
        end else if (run != 0) begin
            vectors++;
            if (run != NT) begin
                miscompares++;
                $display("FAIL pulse_run: got %0d contiguous pulses, required %0d", run, NT);
            end
            run = 0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Drives one beat starting at a negedge; returns at the negedge after acceptance.
    task automatic send_beat(input word_t d, input logic last, output int waits);
        waits = 0;
        coef_bus.i_coef_valid = 1'b1;
        coef_bus.i_coef       = d;
        coef_bus.i_coef_last  = last;
        while (coef_bus.o_coef_ready !== 1'b1 && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        if (waits >= 50) begin
            vectors++;
            miscompares++;
            $display("FAIL ready_timeout: ready stayed %b, required 1", coef_bus.o_coef_ready);
        end
        @(negedge clk);
        coef_bus.i_coef_valid = 1'b0;
        coef_bus.i_coef_last  = 1'b0;
    endtask

    task automatic send_set(input set_t s, input logic good, input int max_gap,
                            output int first_wait);
        int w;
        first_wait = 0;
        for (int i = 0; i < NT; i++) begin
            if (max_gap > 0) repeat ($urandom_range(max_gap, 0)) @(negedge clk);
            if (good && i == NT - 1) begin
                for (int k = NT - 1; k >= 0; k--) exp_q.push_back(s[k]);
            end
            send_beat(s[i], good && (i == NT - 1), w);
            if (i == 0) first_wait = w;
        end
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_done_timeout: o_done=%b after %0d cycles, required 1", tag, done, n);
        end
    endtask

    task automatic test_reset();
        coef_bus.i_coef_valid = 1'b0;
        coef_bus.i_coef       = '0;
        coef_bus.i_coef_last  = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({tap_wr, tap, busy, done, err, coef_bus.o_coef_ready} !== {1'b0, 16'h0, 4'b0001}) begin
            miscompares++;
            $display("FAIL reset_values: got wr=%b tap=%h busy=%b done=%b err=%b ready=%b, required 0 0000 0 0 0 1",
                     tap_wr, tap, busy, done, err, coef_bus.o_coef_ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        set_t s = '{16'd1, 16'd2, 16'd3, 16'd4};
        int w;
        send_set(s, 1'b1, 0, w);
        vectors++;
        if ({tap_wr, busy, coef_bus.o_coef_ready} !== 3'b110) begin
            miscompares++;
            $display("FAIL basic_shift_start: wr/busy/ready=%b%b%b, required 110",
                     tap_wr, busy, coef_bus.o_coef_ready);
        end
        repeat (4) @(negedge clk);
        vectors++;
        if ({done, tap_wr, busy, coef_bus.o_coef_ready} !== 4'b1001) begin
            miscompares++;
            $display("FAIL basic_done_cycle: done/wr/busy/ready=%b%b%b%b, required 1001",
                     done, tap_wr, busy, coef_bus.o_coef_ready);
        end
        for (int k = 0; k < NT; k++) begin
            vectors++;
            if (chain[k] !== s[k]) begin
                miscompares++;
                $display("FAIL basic_chain[%0d]: got %h, required %h", k, chain[k], s[k]);
            end
        end
    endtask

    task automatic test_short_frame();
        set_t s = '{16'd5, 16'd6, 16'd7, 16'd8};
        int w;
        int e0 = errs;
        send_beat(16'd1, 1'b0, w);
        send_beat(16'd2, 1'b1, w);
        vectors++;
        if ({err, tap_wr, busy} !== 3'b100) begin
            miscompares++;
            $display("FAIL short_err: err/wr/busy=%b%b%b, required 100", err, tap_wr, busy);
        end
        send_set(s, 1'b1, 0, w);
        wait_done("short");
        @(negedge clk);
        vectors++;
        if (errs - e0 != 1) begin
            miscompares++;
            $display("FAIL short_err_count: got %0d error pulses, required 1", errs - e0);
        end
    endtask

    task automatic test_long_frame();
        set_t bad  = '{16'd9, 16'd10, 16'd11, 16'd12};
        set_t good = '{16'h0101, 16'h0202, 16'h0303, 16'h0404};
        int w;
        send_set(bad, 1'b0, 0, w);
        vectors++;
        if ({err, tap_wr, coef_bus.o_coef_ready} !== 3'b101) begin
            miscompares++;
            $display("FAIL long_err: err/wr/ready=%b%b%b, required 101",
                     err, tap_wr, coef_bus.o_coef_ready);
        end
        send_set(good, 1'b1, 0, w);
        wait_done("long");
        for (int k = 0; k < NT; k++) begin
            vectors++;
            if (chain[k] !== good[k]) begin
                miscompares++;
                $display("FAIL long_chain[%0d]: got %h, required %h", k, chain[k], good[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        set_t a = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        set_t b = '{16'hA001, 16'hA002, 16'hA003, 16'hA004};
        int w;
        send_set(a, 1'b1, 0, w);
        send_set(b, 1'b1, 0, w);
        vectors++;
        if (w != NT) begin
            miscompares++;
            $display("FAIL b2b_stall: ready low for %0d cycles, required %0d", w, NT);
        end
        wait_done("b2b");
        for (int k = 0; k < NT; k++) begin
            vectors++;
            if (chain[k] !== b[k]) begin
                miscompares++;
                $display("FAIL b2b_chain[%0d]: got %h, required %h", k, chain[k], b[k]);
            end
        end
    endtask

    task automatic test_reset_mid_shift();
        set_t c = '{16'hC001, 16'hC002, 16'hC003, 16'hC004};
        set_t d = '{16'hD001, 16'hD002, 16'hD003, 16'hD004};
        int w;
        int d0;
        send_set(c, 1'b1, 0, w);
        @(negedge clk);
        vectors++;
        if (tap_wr !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_pre_wr: o_tap_wr=%b, required 1", tap_wr);
        end
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if ({tap_wr, busy, coef_bus.o_coef_ready} !== 3'b001) begin
            miscompares++;
            $display("FAIL rst_async_drop: wr/busy/ready=%b%b%b, required 001",
                     tap_wr, busy, coef_bus.o_coef_ready);
        end
        exp_q.delete();
        run = 0;
        d0  = dones;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        vectors++;
        if (dones != d0 || coef_bus.o_coef_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_no_done: done pulses=%0d ready=%b, required 0 and 1",
                     dones - d0, coef_bus.o_coef_ready);
        end
        send_set(d, 1'b1, 0, w);
        wait_done("rst_reload");
    endtask

    task automatic test_random();
        set_t s;
        int   w;
        int   p0;
        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < NT; i++) begin
                case ($urandom_range(3, 0))
                    0:       s[i] = 16'h8000;
                    1:       s[i] = 16'h7FFF;
                    default: s[i] = word_t'($urandom);
                endcase
            end
            p0 = pulses;
            send_set(s, 1'b1, 3, w);
            wait_done("rand");
            @(negedge clk);
            vectors++;
            if (pulses - p0 != NT) begin
                miscompares++;
                $display("FAIL rand_pulse_count: set %0d got %0d pulses, required %0d", n, pulses - p0, NT);
            end
            for (int k = 0; k < NT; k++) begin
                vectors++;
                if (chain[k] !== s[k]) begin
                    miscompares++;
                    $display("FAIL rand_chain[%0d]: set %0d got %h, required %h", k, n, chain[k], s[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_short_frame();
        test_long_frame();
        test_back_to_back();
        test_reset_mid_shift();
        test_random();
        repeat (3) @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d expected pulses outstanding, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
